// File: rtl/raw_acc_scheduler_if.sv
// Request/issue bundle between the force-update source, the RAW issue
// controller and the accumulator. Source drives i_valid/i_particle_id/i_flush;
// the controller returns o_ready, the issued update with its forwarding tag,
// the drain-complete pulse and the saturating hazard counter.
interface raw_acc_scheduler_if #(
  parameter int PARTICLE_ID_WIDTH = 9,
  parameter int COUNTDOWN_WIDTH   = 2
);
  logic                         i_valid;
  logic [PARTICLE_ID_WIDTH-1:0] i_particle_id;
  logic                         o_ready;
  logic                         i_flush;
  logic                         o_issue_valid;
  logic [PARTICLE_ID_WIDTH-1:0] o_issue_particle_id;
  logic                         o_issue_fwd;
  logic [COUNTDOWN_WIDTH-1:0]   o_issue_countdown;
  logic                         o_flush_done;
  logic [15:0]                  o_hazard_count;

  // Request source side.
  modport master (
    output i_valid, i_particle_id, i_flush,
    input  o_ready, o_issue_valid, o_issue_particle_id, o_issue_fwd,
           o_issue_countdown, o_flush_done, o_hazard_count
  );

  // Scheduler side.
  modport slave (
    input  i_valid, i_particle_id, i_flush,
    output o_ready, o_issue_valid, o_issue_particle_id, o_issue_fwd,
           o_issue_countdown, o_flush_done, o_hazard_count
  );
endinterface

// File: rtl/raw_acc_scheduler.sv
// RAW-hazard issue controller for the force accumulator pipeline.
// Latency: issue is combinational from registered state (0 cycles); tracker,
// slots and counter update on the clock. Backpressure: o_ready drops while
// draining, or when a hazard needs a forwarding slot and both are committed.
// Ports: clk, rst (sync, active-high), bus (raw_acc_scheduler_if.slave).
module raw_acc_scheduler #(
  parameter int PARTICLE_ID_WIDTH = 9,
  parameter int ACC_LATENCY       = 3,
  parameter int COUNTDOWN_WIDTH   = 2,
  parameter int NUM_FWD_SLOTS     = 2
) (
  input logic               clk,
  input logic               rst,
  raw_acc_scheduler_if.slave bus
);

  localparam int IDW = PARTICLE_ID_WIDTH;
  localparam int CW  = COUNTDOWN_WIDTH;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } stage_t;

  typedef struct packed {
    logic          busy;
    logic [CW-1:0] remaining;
  } slot_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  stage_t [ACC_LATENCY-1:0]   stage_q, stage_nxt;
  slot_t  [NUM_FWD_SLOTS-1:0] slot_q, slot_nxt;
  state_t                     state_q, state_nxt;
  logic   [15:0]              hazard_cnt_q;

  logic           req_valid;
  logic [IDW-1:0] req_id;
  logic           flush;
  logic           hazard;
  logic [CW-1:0]  countdown;
  logic           all_busy;
  logic           ready;
  logic           issue_valid;
  logic           issue_fwd;
  logic           drain_clear;

  assign req_valid = bus.i_valid;
  assign req_id    = bus.i_particle_id;
  assign flush     = bus.i_flush;

  // Youngest-match search: walk oldest to youngest so the smallest stage
  // index that matches is the last one written.
  always_comb begin
    hazard    = 1'b0;
    countdown = '0;
    for (int s = ACC_LATENCY - 1; s >= 0; s--) begin
      if (stage_q[s].vld && (stage_q[s].id == req_id)) begin
        hazard    = 1'b1;
        countdown = CW'(ACC_LATENCY - 1 - s);
      end
    end
  end

  // A slot in its final (remaining==0) cycle still counts as busy.
  always_comb begin
    all_busy = 1'b1;
    for (int k = 0; k < NUM_FWD_SLOTS; k++) begin
      if (!slot_q[k].busy) all_busy = 1'b0;
    end
  end

  // Reset forces every output low, including the handshake.
  assign ready       = !rst && (state_q == ST_RUN) && !(hazard && all_busy);
  assign issue_valid = req_valid && ready;
  assign issue_fwd   = hazard && issue_valid;

  // Tracker shift; the oldest entry falls off the end.
  always_comb begin
    stage_nxt        = stage_q;
    stage_nxt[0].vld = issue_valid;
    stage_nxt[0].id  = req_id;
    for (int s = 1; s < ACC_LATENCY; s++) begin
      stage_nxt[s] = stage_q[s-1];
    end
  end

  // Slot ageing and allocation. The allocation cycle is itself the first
  // elapsed cycle of the countdown, so the stored value is one less than the
  // issued countdown (floored at 0). Only a slot that is free this cycle can
  // be allocated, and at most one per cycle.
  always_comb begin
    logic allocated;
    allocated = 1'b0;
    slot_nxt  = slot_q;
    for (int k = 0; k < NUM_FWD_SLOTS; k++) begin
      if (slot_q[k].busy) begin
        if (slot_q[k].remaining == '0) begin
          slot_nxt[k] = '0;
        end else begin
          slot_nxt[k].remaining = slot_q[k].remaining - CW'(1);
        end
      end else if (issue_fwd && !allocated) begin
        slot_nxt[k].busy      = 1'b1;
        slot_nxt[k].remaining = (countdown == '0) ? '0 : countdown - CW'(1);
        allocated             = 1'b1;
      end
    end
  end

  // Drain is complete when, after this edge, every in-flight entry is in its
  // final cycle: only the last tracker stage may still hold a result (it is
  // at the accumulator output during the DONE cycle) and every busy slot is
  // on its last cycle. The done pulse thus lines up with the last result.
  always_comb begin
    drain_clear = 1'b1;
    for (int s = 0; s < ACC_LATENCY - 1; s++) begin
      if (stage_nxt[s].vld) drain_clear = 1'b0;
    end
    for (int k = 0; k < NUM_FWD_SLOTS; k++) begin
      if (slot_nxt[k].busy && (slot_nxt[k].remaining != '0)) drain_clear = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_RUN:   if (flush) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_clear) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      stage_q      <= '0;
      slot_q       <= '0;
      hazard_cnt_q <= '0;
    end else begin
      state_q <= state_nxt;
      stage_q <= stage_nxt;
      slot_q  <= slot_nxt;
      if (issue_fwd && (hazard_cnt_q != 16'hFFFF)) begin
        hazard_cnt_q <= hazard_cnt_q + 16'd1;
      end
    end
  end

  assign bus.o_ready             = ready;
  assign bus.o_issue_valid       = issue_valid;
  assign bus.o_issue_particle_id = req_id;
  assign bus.o_issue_fwd         = issue_fwd;
  assign bus.o_issue_countdown   = issue_fwd ? countdown : '0;
  assign bus.o_flush_done        = !rst && (state_q == ST_DONE);
  assign bus.o_hazard_count      = hazard_cnt_q;

endmodule

// File: tb/tb_raw_acc_scheduler.sv
// Directed bench for raw_acc_scheduler (ACC_LATENCY=3): table of per-cycle
// vectors with hand-computed expectations, then a long hazard stream for
// counter saturation followed by a mid-stream reset.
module tb_raw_acc_scheduler;

  logic clk;
  logic rst;

  raw_acc_scheduler_if #(.PARTICLE_ID_WIDTH(9), .COUNTDOWN_WIDTH(2)) bus ();

  raw_acc_scheduler #(
    .PARTICLE_ID_WIDTH(9),
    .ACC_LATENCY(3),
    .COUNTDOWN_WIDTH(2),
    .NUM_FWD_SLOTS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       vld;
    logic [8:0] id;
    logic       flush;
    logic       e_rdy;
    logic       e_fwd;
    logic [1:0] e_cd;
    logic       e_done;
    int         e_cnt;   // -1: not checked
  } vec_t;

  vec_t vecs[$];
  int   passed;
  int   total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic add(input logic r, input logic v, input int id, input logic f,
                     input logic e_rdy, input logic e_fwd, input int e_cd,
                     input logic e_done, input int e_cnt);
    vec_t t;
    t.rst    = r;
    t.vld    = v;
    t.id     = 9'(id);
    t.flush  = f;
    t.e_rdy  = e_rdy;
    t.e_fwd  = e_fwd;
    t.e_cd   = 2'(e_cd);
    t.e_done = e_done;
    t.e_cnt  = e_cnt;
    vecs.push_back(t);
  endtask

  // Reset row: every combinational output must read 0 while rst is high.
  task automatic add_rst(input int e_cnt);
    add(1, 0, 0, 0, 0, 0, 0, 0, e_cnt);
  endtask

  initial begin
    int bad;
    rst               = 1'b1;
    bus.i_valid       = 1'b0;
    bus.i_particle_id = '0;
    bus.i_flush       = 1'b0;
    passed            = 0;
    total             = 0;

    //      rst v  id f  rdy fwd cd done cnt
    // Back-to-back same id: second is a hazard at stage 0.
    add_rst(0);
    add(0, 1, 5, 0, 1, 0, 0, 0, 0);
    add(0, 1, 5, 0, 1, 1, 2, 0, 0);
    // 5,7,5: match at stage 1; 7 never forwards; counter ends at 1.
    add_rst(-1);
    add(0, 1, 5, 0, 1, 0, 0, 0, 0);
    add(0, 1, 7, 0, 1, 0, 0, 0, 0);
    add(0, 1, 5, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    // Gap of two: match in the last stage, countdown 0.
    add_rst(-1);
    add(0, 1, 5, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 5, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    // Gap of three: entry already retired.
    add_rst(-1);
    add(0, 1, 5, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 5, 0, 1, 0, 0, 0, 0);
    // Id 5 held: both slots fill, stall at t3, accepted again at t4.
    add_rst(-1);
    add(0, 1, 5, 0, 1, 0, 0, 0, 0);
    add(0, 1, 5, 0, 1, 1, 2, 0, 0);
    add(0, 1, 5, 0, 1, 1, 2, 0, 1);
    add(0, 1, 5, 0, 0, 0, 0, 0, 2);
    add(0, 1, 5, 0, 1, 1, 1, 0, 2);
    add(0, 1, 5, 0, 1, 1, 2, 0, 3);
    add(0, 0, 0, 0, 1, 0, 0, 0, 4);
    // Same, but a non-hazard id at t3 is not blocked by full slots.
    add_rst(-1);
    add(0, 1, 5, 0, 1, 0, 0, 0, 0);
    add(0, 1, 5, 0, 1, 1, 2, 0, 0);
    add(0, 1, 5, 0, 1, 1, 2, 0, 1);
    add(0, 1, 9, 0, 1, 0, 0, 0, 2);
    // Flush with a same-cycle request; flush during drain is ignored.
    add_rst(-1);
    add(0, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 1, 2, 0, 1, 0, 0, 0, 0);
    add(0, 1, 3, 1, 1, 0, 0, 0, 0);
    add(0, 1, 3, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      rst               = v.rst;
      bus.i_valid       = v.vld;
      bus.i_particle_id = v.id;
      bus.i_flush       = v.flush;
      #2;
      chk($sformatf("v%0d_ready", i), bus.o_ready, v.e_rdy);
      chk($sformatf("v%0d_issue_valid", i), bus.o_issue_valid, v.vld && v.e_rdy);
      chk($sformatf("v%0d_issue_id", i), bus.o_issue_particle_id, v.id);
      chk($sformatf("v%0d_fwd", i), bus.o_issue_fwd, v.e_fwd);
      chk($sformatf("v%0d_countdown", i), bus.o_issue_countdown, v.e_cd);
      chk($sformatf("v%0d_flush_done", i), bus.o_flush_done, v.e_done);
      if (v.e_cnt >= 0) chk($sformatf("v%0d_hazard_count", i), bus.o_hazard_count, v.e_cnt);
    end

    // Period-3 id stream: from the fourth issue on, every request matches
    // the last stage (countdown 0), one hazard per cycle, never stalled.
    @(negedge clk);
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    bad         = 0;
    for (int i = 0; i < 70003; i++) begin
      @(negedge clk);
      rst               = 1'b0;
      bus.i_valid       = 1'b1;
      bus.i_particle_id = 9'((i % 3) + 1);
      #2;
      if (i >= 3 && !(bus.o_ready && bus.o_issue_fwd && bus.o_issue_countdown == 2'd0)) bad++;
      if (i == 1003) chk("hazard_count_1000", bus.o_hazard_count, 1000);
    end
    chk("stream_fwd_bad_cycles", bad, 0);

    // 70000 hazards issued: counter saturated. Reset asserted here.
    @(negedge clk);
    rst               = 1'b1;
    bus.i_valid       = 1'b0;
    bus.i_particle_id = '0;
    #2;
    chk("hazard_count_saturated", bus.o_hazard_count, 16'hFFFF);

    @(negedge clk);
    #2;
    chk("rst_ready", bus.o_ready, 0);
    chk("rst_issue_valid", bus.o_issue_valid, 0);
    chk("rst_issue_id", bus.o_issue_particle_id, 0);
    chk("rst_fwd", bus.o_issue_fwd, 0);
    chk("rst_countdown", bus.o_issue_countdown, 0);
    chk("rst_flush_done", bus.o_flush_done, 0);
    chk("rst_hazard_count", bus.o_hazard_count, 0);

    // Id 1 was in the tracker before reset; it must not forward now.
    @(negedge clk);
    rst               = 1'b0;
    bus.i_valid       = 1'b1;
    bus.i_particle_id = 9'd1;
    #2;
    chk("post_rst_ready", bus.o_ready, 1);
    chk("post_rst_fwd", bus.o_issue_fwd, 0);
    chk("post_rst_hazard_count", bus.o_hazard_count, 0);

    @(negedge clk);
    bus.i_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
